// File: rtl/keypad_scanner.sv
// Purpose : 4x4 keypad scanner; one active-low column at a time, 2-flop row sync, tick-based debounce, one code per press.
// Latency : press-to-key_valid = 2 sync cycles + column wait (<= 4*SCAN_DIV) + (DEBOUNCE_N-1)*SCAN_DIV + 1 cycle.
// Backpr. : none; key_valid is a 1-cycle pulse that the consumer must take when it appears.
//
// Ports:
//   CLK, RESET (sync, active-high), EN (0 = idle, columns released)
//   kb_row    : raw active-low rows, asynchronous to CLK
//   kb_col    : active-low column drive, at most one bit low
//   key_code  : last accepted key, changes only with key_valid or reset
//   key_valid : 1-cycle accept pulse
//   key_held  : high from accept until the release is debounced
// Optional feature: define KEYPAD_REPEAT_EN to build the auto-repeat hold counter.
module keypad_scanner #(
  parameter int SCAN_DIV     = 10,
  parameter int DEBOUNCE_N   = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [3:0] kb_row,
  output logic [3:0] kb_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

  state_t           r_state;
  logic [3:0]       r_row_s1;
  logic [3:0]       r_row_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [1:0]       r_cand_row;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic [3:0]       r_kb_col;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_W = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam logic [HOLD_W-1:0] DELAY_V = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] RATE_V  = HOLD_W'(REPEAT_RATE);
  logic [HOLD_W-1:0] r_hold;
  logic              r_rep_first;   // next repeat uses the initial delay
  logic [HOLD_W-1:0] w_hold_inc;
  logic [HOLD_W-1:0] w_hold_tgt;
  assign w_hold_inc = r_hold + HOLD_W'(1);
  assign w_hold_tgt = r_rep_first ? DELAY_V : RATE_V;
`endif

  logic       w_tick;
  logic       w_single;
  logic [1:0] w_row_idx;
  logic       w_cand_low;
  logic [1:0] w_col_next;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_cand_low = ~r_row_s2[r_cand_row];
  assign w_col_next = r_col + 2'd1;

  // A sample qualifies only when exactly one row is pulled low.
  always_comb begin
    w_single  = 1'b0;
    w_row_idx = 2'd0;
    case (r_row_s2)
      4'b1110: begin w_single = 1'b1; w_row_idx = 2'd0; end
      4'b1101: begin w_single = 1'b1; w_row_idx = 2'd1; end
      4'b1011: begin w_single = 1'b1; w_row_idx = 2'd2; end
      4'b0111: begin w_single = 1'b1; w_row_idx = 2'd3; end
      default: begin w_single = 1'b0; w_row_idx = 2'd0; end
    endcase
  end

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_row_s1    <= 4'hF;
      r_row_s2    <= 4'hF;
      r_state     <= S_SCAN;
      r_div       <= '0;
      r_col       <= 2'd0;
      r_cand_row  <= 2'd0;
      r_cnt       <= '0;
      r_rel_cnt   <= '0;
      r_kb_col    <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_hold      <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_row_s1    <= kb_row;
      r_row_s2    <= r_row_s1;
      r_key_valid <= 1'b0;
      if (!EN) begin
        r_state    <= S_SCAN;
        r_div      <= '0;
        r_col      <= 2'd0;
        r_cnt      <= '0;
        r_rel_cnt  <= '0;
        r_kb_col   <= 4'b1111;
        r_key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
        r_hold      <= '0;
        r_rep_first <= 1'b1;
`endif
      end else begin
        r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
        r_kb_col <= col_drive(r_col);   // overridden below when the column advances
        if (w_tick) begin
          case (r_state)
            S_SCAN: begin
              if (w_single) begin
                r_cand_row <= w_row_idx;
                r_cnt      <= CNT_W'(1);
                r_state    <= S_DEBOUNCE;
              end else begin
                r_col    <= w_col_next;
                r_kb_col <= col_drive(w_col_next);
              end
            end
            S_DEBOUNCE: begin
              if (w_single && (w_row_idx == r_cand_row)) begin
                if (r_cnt == CNT_LAST) begin
                  // Column is frozen, so r_col is still the candidate column.
                  r_key_code  <= key_map(w_row_idx, r_col);
                  r_key_valid <= 1'b1;
                  r_key_held  <= 1'b1;
                  r_rel_cnt   <= '0;
                  r_state     <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
                  r_hold      <= '0;
                  r_rep_first <= 1'b1;
`endif
                end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end
              end else begin
                r_cnt    <= '0;
                r_state  <= S_SCAN;
                r_col    <= w_col_next;
                r_kb_col <= col_drive(w_col_next);
              end
            end
            default: begin  // S_HELD
              if (!w_cand_low) begin
`ifdef KEYPAD_REPEAT_EN
                r_hold <= '0;
`endif
                if (r_rel_cnt == CNT_LAST) begin
                  r_key_held <= 1'b0;
                  r_rel_cnt  <= '0;
                  r_cnt      <= '0;
                  r_state    <= S_SCAN;
                  r_col      <= w_col_next;
                  r_kb_col   <= col_drive(w_col_next);
                end else begin
                  r_rel_cnt <= r_rel_cnt + CNT_W'(1);
                end
              end else begin
                r_rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                if (w_hold_inc == w_hold_tgt) begin
                  r_key_valid <= 1'b1;
                  r_hold      <= '0;
                  r_rep_first <= 1'b0;
                end else begin
                  r_hold <= w_hold_inc;
                end
`endif
              end
            end
          endcase
        end
      end
    end
  end

  assign kb_col    = r_kb_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose : directed bench for keypad_scanner with a keypad matrix model driven from kb_col.
// Latency : timing checks use absolute cycle numbers hand-derived for SCAN_DIV=10, DEBOUNCE_N=4.
// Backpr. : none; every wait on the DUT is bounded.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        EN;
  logic [3:0]  kb_row;
  logic [3:0]  kb_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;        // keys[r*4+c] = 1 when key at row r, col c is pressed
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  int          pcyc[$];
  int          e0;
  int          a0;
  int          base;

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_HOLD_PULSES = 4;
`else
  localparam int EXP_HOLD_PULSES = 1;
`endif

  keypad_scanner #(
    .SCAN_DIV(10), .DEBOUNCE_N(4), .REPEAT_DELAY(50), .REPEAT_RATE(20)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .kb_row(kb_row),
    .kb_col(kb_col), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Matrix: a row reads low when a pressed key sits on a column driven low.
  always_comb begin
    kb_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (kb_col[c] == 1'b0)) kb_row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      pcyc.push_back(cyc);
    end
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      step();
      guard++;
    end
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int start = pulse_cnt;
    int n = 0;
    while (pulse_cnt == start && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(pulse_cnt > start), 32'd1);
  endtask

  task automatic wait_held_low(input string tag, input int budget);
    int n = 0;
    while (key_held === 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(key_held), 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    EN    = 1'b1;
    keys  = 16'h0;
    step();
    step();                                   // cyc 2: two reset edges applied
    chk("rst_kb_col", 32'(kb_col), 32'hE);
    chk("rst_code",   32'(key_code), 32'h0);
    chk("rst_valid",  32'(key_valid), 32'd0);
    chk("rst_held",   32'(key_held), 32'd0);
    RESET = 1'b0;

    // Key '5' (r1,c1): col1 driven from cycle 12, first sampling tick ends at edge 22,
    // accept on the 4th tick at edge 52.
    keys[5] = 1'b1;
    run_to(11);
    chk("col0_dwell", 32'(kb_col), 32'hE);
    step();
    chk("col1_drive", 32'(kb_col), 32'hD);
    wait_pulse("k5_pulse", 100);
    chk("k5_lat", 32'(pcyc[pcyc.size()-1]), 32'd52);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_held", 32'(key_held), 32'd1);
    step();
    chk("k5_one_cycle", 32'(key_valid), 32'd0);
    run_to(70);
    keys[5] = 1'b0;                           // tick at 72 still sees low, 82..112 see high
    run_to(111);
    chk("k5_held_still", 32'(key_held), 32'd1);
    step();
    chk("k5_release", 32'(key_held), 32'd0);
    chk("k5_col_adv", 32'(kb_col), 32'hB);
    chk("k5_code_hold", 32'(key_code), 32'h5);
    chk("k5_count", 32'(pulse_cnt), 32'd1);

    // Key '7' (r2,c0) bouncing: 13-cycle phases never give 4 consecutive low ticks.
    for (int i = 0; i < 6; i++) begin
      keys[8] = ~keys[8];
      repeat (13) step();
    end
    chk("k7_bounce_quiet", 32'(pulse_cnt), 32'd1);
    keys[8] = 1'b1;
    wait_pulse("k7_pulse", 200);
    chk("k7_code", 32'(key_code), 32'h7);
    keys[8] = 1'b0;
    wait_held_low("k7_release", 200);
    chk("k7_count", 32'(pulse_cnt), 32'd2);

    // EN=0 idles the scanner even with a key down.
    EN = 1'b0;
    step();
    chk("en0_kb_col", 32'(kb_col), 32'hF);
    chk("en0_held", 32'(key_held), 32'd0);
    keys[0] = 1'b1;
    repeat (60) step();
    chk("en0_no_pulse", 32'(pulse_cnt), 32'd2);
    chk("en0_kb_col_idle", 32'(kb_col), 32'hF);
    chk("en0_code_hold", 32'(key_code), 32'h7);
    keys[0] = 1'b0;

    // Two rows (r0,r2) low on col3: ignored, columns keep rotating from col0.
    keys[3]  = 1'b1;
    keys[11] = 1'b1;
    repeat (3) step();
    EN = 1'b1;
    e0 = cyc;
    run_to(e0 + 5);
    chk("rot_c0", 32'(kb_col), 32'hE);
    run_to(e0 + 15);
    chk("rot_c1", 32'(kb_col), 32'hD);
    run_to(e0 + 25);
    chk("rot_c2", 32'(kb_col), 32'hB);
    run_to(e0 + 35);
    chk("rot_c3", 32'(kb_col), 32'h7);
    run_to(e0 + 45);
    chk("rot_wrap", 32'(kb_col), 32'hE);
    run_to(e0 + 90);
    chk("multi_no_pulse", 32'(pulse_cnt), 32'd2);
    chk("multi_no_held", 32'(key_held), 32'd0);
    keys = 16'h0;

    // '#' (r3,c2), reset while held, then re-detected.
    keys[14] = 1'b1;
    wait_pulse("kf_pulse", 200);
    chk("kf_code", 32'(key_code), 32'hF);
    repeat (30) step();
    chk("kf_held_pre", 32'(key_held), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_kb_col", 32'(kb_col), 32'hE);
    chk("mid_rst_code",   32'(key_code), 32'h0);
    chk("mid_rst_valid",  32'(key_valid), 32'd0);
    chk("mid_rst_held",   32'(key_held), 32'd0);
    wait_pulse("kf_repulse", 200);
    chk("kf_code2", 32'(key_code), 32'hF);
    chk("kf_count", 32'(pulse_cnt), 32'd4);
    keys[14] = 1'b0;
    wait_held_low("kf_release", 200);

    // '9' (r2,c2) held ~95 ticks past accept.
    base = pcyc.size();
    keys[10] = 1'b1;
    wait_pulse("k9_pulse", 200);
    chk("k9_code", 32'(key_code), 32'h9);
    a0 = pcyc[base];
    run_to(a0 + 950);
    keys[10] = 1'b0;
    wait_held_low("k9_release", 200);
    chk("k9_pulses", 32'(pcyc.size() - base), 32'(EXP_HOLD_PULSES));
    chk("k9_code_hold", 32'(key_code), 32'h9);
`ifdef KEYPAD_REPEAT_EN
    if (pcyc.size() - base == 4) begin
      chk("k9_rep1", 32'(pcyc[base+1] - a0), 32'd500);
      chk("k9_rep2", 32'(pcyc[base+2] - a0), 32'd700);
      chk("k9_rep3", 32'(pcyc[base+3] - a0), 32'd900);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
